// File: rtl/btb_predictor_if.sv
// Bus between fetch/ID-stage logic and the branch target buffer.
// master: fetch + branch-resolution side; drives lookup PC, update and flush.
// slave : the BTB; returns hit/prediction and the registered occupancy.
interface btb_predictor_if #(
    parameter int unsigned ENTRIES = 8,
    parameter int unsigned ADDR_W  = 32
);
    localparam int unsigned OCC_W = $clog2(ENTRIES + 1);

    logic [ADDR_W-1:0] lookup_pc;
    logic              hit;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_next_pc;
    logic              upd_valid;
    logic [ADDR_W-1:0] upd_pc;
    logic              upd_taken;
    logic [ADDR_W-1:0] upd_target;
    logic              flush;
    logic [OCC_W-1:0]  occupancy;

    modport master (
        output lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, flush,
        input  hit, pred_taken, pred_next_pc, occupancy
    );

    modport slave (
        input  lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, flush,
        output hit, pred_taken, pred_next_pc, occupancy
    );
endinterface

// File: rtl/btb_predictor.sv
// Fully associative branch target buffer with saturating direction counters.
// Ports: clk, reset (async, active-low), bus (btb_predictor_if.slave):
//   lookup_pc -> hit / pred_taken / pred_next_pc (combinational),
//   upd_valid/upd_pc/upd_taken/upd_target (one resolved branch per cycle),
//   flush (synchronous invalidate-all), occupancy (registered valid count).
module btb_predictor #(
    parameter int unsigned ENTRIES = 8,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned CTR_W   = 2
) (
    input  logic             clk,
    input  logic             reset,
    btb_predictor_if.slave   bus
);
    localparam int unsigned TAG_W = ADDR_W - 2;
    localparam int unsigned PTR_W = $clog2(ENTRIES);
    localparam int unsigned OCC_W = $clog2(ENTRIES + 1);
    localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1 << (CTR_W - 1));

    logic [ENTRIES-1:0] validQ;
    logic [TAG_W-1:0]   tagQ    [ENTRIES];
    logic [ADDR_W-1:0]  targetQ [ENTRIES];
    logic [CTR_W-1:0]   ctrQ    [ENTRIES];
    logic [PTR_W-1:0]   rrPtr;
    logic [OCC_W-1:0]   occQ;

    logic [TAG_W-1:0]   lookTag, updTag;
    logic               lookHit;
    logic [ADDR_W-1:0]  lookTarget;
    logic [CTR_W-1:0]   lookCtr;
    logic               updHit;
    logic [PTR_W-1:0]   updIdx;
    logic               hasFree;
    logic [PTR_W-1:0]   freeIdx;
    logic [PTR_W-1:0]   victimIdx;

    // Low PC bits never take part in tag compares on the update side.
    logic unusedUpdLow;
    assign unusedUpdLow = ^bus.upd_pc[1:0];

    assign lookTag = bus.lookup_pc[ADDR_W-1:2];
    assign updTag  = bus.upd_pc[ADDR_W-1:2];

    // Lookup: at most one entry matches, so OR-merging the matching payloads is exact.
    always_comb begin
        lookHit    = 1'b0;
        lookTarget = '0;
        lookCtr    = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (validQ[i] && tagQ[i] == lookTag) begin
                lookHit    = 1'b1;
                lookTarget = lookTarget | targetQ[i];
                lookCtr    = lookCtr | ctrQ[i];
            end
        end
    end

    assign bus.hit          = lookHit;
    assign bus.pred_taken   = lookHit & lookCtr[CTR_W-1];
    assign bus.pred_next_pc = bus.pred_taken ? lookTarget : bus.lookup_pc + ADDR_W'(4);
    assign bus.occupancy    = occQ;

    // Update-side match and victim selection (lowest invalid entry, else round-robin).
    always_comb begin
        updHit  = 1'b0;
        updIdx  = '0;
        hasFree = 1'b0;
        freeIdx = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (validQ[i] && tagQ[i] == updTag) begin
                updHit = 1'b1;
                updIdx = PTR_W'(i);
            end
        end
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!validQ[i]) begin
                hasFree = 1'b1;
                freeIdx = PTR_W'(i);
            end
        end
        victimIdx = hasFree ? freeIdx : rrPtr;
    end

    // State update; flush wins over a same-cycle update.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            validQ <= '0;
            rrPtr  <= '0;
            occQ   <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tagQ[i]    <= '0;
                targetQ[i] <= '0;
                ctrQ[i]    <= '0;
            end
        end else if (bus.flush) begin
            validQ <= '0;
            rrPtr  <= '0;
            occQ   <= '0;
        end else if (bus.upd_valid) begin
            if (updHit) begin
                if (bus.upd_taken) begin
                    targetQ[updIdx] <= bus.upd_target;
                    if (ctrQ[updIdx] != CTR_MAX) ctrQ[updIdx] <= ctrQ[updIdx] + CTR_W'(1);
                end else if (ctrQ[updIdx] != '0) begin
                    ctrQ[updIdx] <= ctrQ[updIdx] - CTR_W'(1);
                end
            end else if (bus.upd_taken) begin
                validQ[victimIdx]  <= 1'b1;
                tagQ[victimIdx]    <= updTag;
                targetQ[victimIdx] <= bus.upd_target;
                ctrQ[victimIdx]    <= CTR_WEAK;
                if (hasFree) occQ  <= occQ + OCC_W'(1);
                else         rrPtr <= rrPtr + PTR_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_btb_predictor.sv
// Directed self-checking bench for btb_predictor (ENTRIES=8, ADDR_W=32, CTR_W=2).
module tb_btb_predictor;
    localparam int unsigned ENTRIES = 8;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned CTR_W   = 2;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   errors  = 0;

    btb_predictor_if #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W)) bus ();

    btb_predictor #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W), .CTR_W(CTR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive a lookup and check all three combinational outputs.
    task automatic look(input string tag, input logic [31:0] pc, input logic h,
                        input logic pt, input logic [31:0] npc);
        bus.lookup_pc = pc;
        #1;
        chk({tag, ".hit"}, 32'(bus.hit), 32'(h));
        chk({tag, ".taken"}, 32'(bus.pred_taken), 32'(pt));
        chk({tag, ".npc"}, bus.pred_next_pc, npc);
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = pc;
        bus.upd_taken  = tk;
        bus.upd_target = tgt;
        @(posedge clk);
        #1;
        bus.upd_valid = 1'b0;
    endtask

    task automatic doFlush();
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
    endtask

    initial begin
        reset          = 1'b0;
        bus.lookup_pc  = 32'h0;
        bus.upd_valid  = 1'b0;
        bus.upd_pc     = 32'h0;
        bus.upd_taken  = 1'b0;
        bus.upd_target = 32'h0;
        bus.flush      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        look("rst_hold", 32'h40, 1'b0, 1'b0, 32'h44);
        chk("rst_hold.occ", 32'(bus.occupancy), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        look("rst_rel", 32'h40, 1'b0, 1'b0, 32'h44);
        chk("rst_rel.occ", 32'(bus.occupancy), 32'd0);
        look("wrap_miss", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

        // Allocate and train one entry.
        upd(32'h100, 1'b1, 32'h200);                      // ctr 2
        look("alloc", 32'h100, 1'b1, 1'b1, 32'h200);
        chk("alloc.occ", 32'(bus.occupancy), 32'd1);
        look("lowbits", 32'h102, 1'b1, 1'b1, 32'h200);
        upd(32'h100, 1'b0, 32'h0);                        // ctr 1
        look("nt1", 32'h100, 1'b1, 1'b0, 32'h104);
        upd(32'h100, 1'b0, 32'h0);                        // ctr 0
        look("nt2", 32'h100, 1'b1, 1'b0, 32'h104);
        upd(32'h100, 1'b0, 32'h0);                        // ctr stays 0
        upd(32'h100, 1'b1, 32'h200);                      // ctr 1
        look("sat0", 32'h100, 1'b1, 1'b0, 32'h104);
        upd(32'h100, 1'b1, 32'h280);                      // ctr 2, new target
        look("retarget", 32'h100, 1'b1, 1'b1, 32'h280);
        upd(32'h100, 1'b1, 32'h280);                      // ctr 3
        upd(32'h100, 1'b1, 32'h280);                      // ctr stays 3
        upd(32'h100, 1'b0, 32'h999);                      // ctr 2, target kept
        look("sat3", 32'h100, 1'b1, 1'b1, 32'h280);
        upd(32'h100, 1'b0, 32'h0);                        // ctr 1
        look("sat3b", 32'h100, 1'b1, 1'b0, 32'h104);
        chk("train.occ", 32'(bus.occupancy), 32'd1);

        // Not-taken miss does not allocate.
        upd(32'h300, 1'b0, 32'h500);
        look("nt_miss", 32'h300, 1'b0, 1'b0, 32'h304);
        chk("nt_miss.occ", 32'(bus.occupancy), 32'd1);

        // Flush beats a same-cycle taken update.
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = 32'h400;
        bus.upd_taken  = 1'b1;
        bus.upd_target = 32'h800;
        doFlush();
        bus.upd_valid = 1'b0;
        chk("flush.occ", 32'(bus.occupancy), 32'd0);
        look("flush.old", 32'h100, 1'b0, 1'b0, 32'h104);
        look("flush.new", 32'h400, 1'b0, 1'b0, 32'h404);

        // Fill all entries, then evict round-robin.
        for (int i = 0; i < 8; i++) upd(32'h1000 + 32'(4 * i), 1'b1, 32'h5000 + 32'(4 * i));
        chk("fill.occ", 32'(bus.occupancy), 32'd8);
        look("fill.last", 32'h101C, 1'b1, 1'b1, 32'h501C);
        look("fill.first", 32'h1000, 1'b1, 1'b1, 32'h5000);
        upd(32'h2000, 1'b1, 32'h6000);
        look("evict0.old", 32'h1000, 1'b0, 1'b0, 32'h1004);
        look("evict0.new", 32'h2000, 1'b1, 1'b1, 32'h6000);
        chk("evict0.occ", 32'(bus.occupancy), 32'd8);
        upd(32'h2004, 1'b1, 32'h6004);
        look("evict1.old", 32'h1004, 1'b0, 1'b0, 32'h1008);
        look("evict1.keep", 32'h1008, 1'b1, 1'b1, 32'h5008);
        for (int i = 2; i < 8; i++) upd(32'h2000 + 32'(4 * i), 1'b1, 32'h6000 + 32'(4 * i));
        look("evict7.old", 32'h101C, 1'b0, 1'b0, 32'h1020);
        look("evict7.new", 32'h201C, 1'b1, 1'b1, 32'h601C);
        upd(32'h3000, 1'b1, 32'h7000);                    // pointer wrapped: hits entry 0
        look("wrap.old", 32'h2000, 1'b0, 1'b0, 32'h2004);
        look("wrap.keep", 32'h2004, 1'b1, 1'b1, 32'h6004);
        look("wrap.new", 32'h3000, 1'b1, 1'b1, 32'h7000);

        // No same-cycle bypass.
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = 32'h4000;
        bus.upd_taken  = 1'b1;
        bus.upd_target = 32'h4400;
        look("bypass.pre", 32'h4000, 1'b0, 1'b0, 32'h4004);
        @(posedge clk);
        #1;
        bus.upd_valid = 1'b0;
        look("bypass.post", 32'h4000, 1'b1, 1'b1, 32'h4400);

        // Async reset with five valid entries.
        doFlush();
        for (int i = 0; i < 5; i++) upd(32'h6000 + 32'(4 * i), 1'b1, 32'h9000 + 32'(4 * i));
        chk("pre_arst.occ", 32'(bus.occupancy), 32'd5);
        look("pre_arst", 32'h6010, 1'b1, 1'b1, 32'h9010);
        #1;
        reset = 1'b0;
        #1;
        look("arst", 32'h6000, 1'b0, 1'b0, 32'h6004);
        chk("arst.occ", 32'(bus.occupancy), 32'd0);
        reset = 1'b1;
        upd(32'h7000, 1'b1, 32'hA000);
        look("post_arst", 32'h7000, 1'b1, 1'b1, 32'hA000);
        chk("post_arst.occ", 32'(bus.occupancy), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
